// File: rtl/ddr4_ca_lane_ctrl.sv
// ============================================================================
// Module : ddr4_ca_lane_ctrl
// Desc   : DDR4 CA lane controller: 4:1 TX/OE word register with idle fill,
//          plus per-lane IOD output-delay sequencer. Option: CA_ADJ_CMD_BLOCK_EN
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ddr4_ca_lane_ctrl #(
  parameter int                   NUM_LANES    = 8,
  parameter int                   TAP_W        = 8,
  parameter int                   LOAD_TAP     = 1,
  parameter int                   MOVE_GAP     = 4,
  parameter logic [NUM_LANES-1:0] IDLE_PATTERN = '1
) (
  input  logic                         FAB_CLK,
  input  logic                         ARST_N,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [4*NUM_LANES-1:0]       cmd_data,
  input  logic [4*NUM_LANES-1:0]       cmd_oe,
  output logic [4*NUM_LANES-1:0]       TX_DATA,
  output logic [4*NUM_LANES-1:0]       OE_DATA,
  input  logic                         adj_req,
  input  logic [$clog2(NUM_LANES)-1:0] adj_lane,
  input  logic                         adj_load,
  input  logic [TAP_W-1:0]             adj_target,
  output logic                         adj_busy,
  output logic                         adj_done,
  output logic                         adj_err,
  input  logic [$clog2(NUM_LANES)-1:0] tap_rd_lane,
  output logic [TAP_W-1:0]             tap_rd_data,
  output logic [NUM_LANES-1:0]         DELAY_LINE_MOVE,
  output logic [NUM_LANES-1:0]         DELAY_LINE_DIRECTION,
  output logic [NUM_LANES-1:0]         DELAY_LINE_LOAD,
  input  logic [NUM_LANES-1:0]         DELAY_LINE_OUT_OF_RANGE
);

  function automatic logic [4*NUM_LANES-1:0] f_idle_word();
    logic [4*NUM_LANES-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_LANES; i++) v[4*i +: 4] = {4{IDLE_PATTERN[i]}};
    return v;
  endfunction

  localparam logic [4*NUM_LANES-1:0] c_idle_word = f_idle_word();
  localparam int                     c_gap_w     = (MOVE_GAP > 1) ? $clog2(MOVE_GAP + 1) : 1;
  localparam logic [c_gap_w-1:0]     c_gap_init  = c_gap_w'(MOVE_GAP - 1);
  localparam logic [TAP_W-1:0]       c_load_tap  = TAP_W'(LOAD_TAP);

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_IDLE = 3'd1,
    S_LOAD = 3'd2,
    S_MOVE = 3'd3,
    S_GAP  = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  state_t                        r_state, w_state_nxt;
  logic                          r_init_go;
  logic [$clog2(NUM_LANES)-1:0]  r_lane;
  logic [TAP_W-1:0]              r_target;
  logic [TAP_W-1:0]              r_prev_tap;
  logic [c_gap_w-1:0]            r_gap_cnt;
  logic [TAP_W-1:0]              r_tap [NUM_LANES];
  logic [4*NUM_LANES-1:0]        r_tx, r_oe;

  logic [TAP_W-1:0]              w_cur_tap, w_step_tap;
  logic                          w_up, w_tgt_eq, w_gap_last, w_oor, w_block;
  logic [NUM_LANES-1:0]          w_move, w_dir, w_load;

  assign w_cur_tap  = r_tap[r_lane];
  assign w_up       = (r_target > w_cur_tap);
  assign w_tgt_eq   = (w_cur_tap == r_target);
  assign w_gap_last = (r_gap_cnt == '0);
  assign w_oor      = DELAY_LINE_OUT_OF_RANGE[r_lane];
  // Saturate at the counter ends; the IOD flag is the real range guard.
  assign w_step_tap = w_up ? ((w_cur_tap == '1) ? w_cur_tap : w_cur_tap + 1'b1)
                           : ((w_cur_tap == '0) ? w_cur_tap : w_cur_tap - 1'b1);

  // Holds INIT one extra cycle so the broadcast load never overlaps reset.
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) r_init_go <= 1'b0;
    else         r_init_go <= 1'b1;
  end

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) r_state <= S_INIT;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_move      = '0;
    w_dir       = '0;
    w_load      = '0;
    case (r_state)
      S_INIT: begin
        if (r_init_go) begin
          w_load      = '1;
          w_state_nxt = S_IDLE;
        end
      end
      S_IDLE: begin
        if (adj_req) begin
          if (adj_load)                           w_state_nxt = S_LOAD;
          else if (r_tap[adj_lane] == adj_target) w_state_nxt = S_DONE;
          else                                    w_state_nxt = S_MOVE;
        end
      end
      S_LOAD: begin
        w_load[r_lane] = 1'b1;
        w_state_nxt    = S_DONE;
      end
      S_MOVE: begin
        w_move[r_lane] = 1'b1;
        w_dir[r_lane]  = w_up;
        w_state_nxt    = S_GAP;
      end
      S_GAP: begin
        if (w_gap_last) begin
          if (w_oor)         w_state_nxt = S_ERR;
          else if (w_tgt_eq) w_state_nxt = S_DONE;
          else               w_state_nxt = S_MOVE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      S_ERR:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      for (int i = 0; i < NUM_LANES; i++) r_tap[i] <= c_load_tap;
      r_lane     <= '0;
      r_target   <= '0;
      r_prev_tap <= '0;
      r_gap_cnt  <= '0;
    end else begin
      if (r_state == S_IDLE && adj_req) begin
        r_lane   <= adj_lane;
        r_target <= adj_target;
      end
      case (r_state)
        S_INIT: begin
          if (r_init_go) begin
            for (int i = 0; i < NUM_LANES; i++) r_tap[i] <= c_load_tap;
          end
        end
        S_LOAD: r_tap[r_lane] <= c_load_tap;
        S_MOVE: begin
          r_prev_tap     <= w_cur_tap;
          r_tap[r_lane]  <= w_step_tap;
          r_gap_cnt      <= c_gap_init;
        end
        S_GAP: begin
          if (w_gap_last) begin
            if (w_oor) r_tap[r_lane] <= r_prev_tap;
          end else begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign adj_busy             = (r_state != S_IDLE);
  assign adj_done             = (r_state == S_DONE);
  assign adj_err              = (r_state == S_ERR);
  assign tap_rd_data          = r_tap[tap_rd_lane];
  assign DELAY_LINE_MOVE      = w_move;
  assign DELAY_LINE_DIRECTION = w_dir;
  assign DELAY_LINE_LOAD      = w_load;

`ifdef CA_ADJ_CMD_BLOCK_EN
  assign cmd_ready = ~adj_busy;
  assign w_block   = adj_busy;
`else
  assign cmd_ready = 1'b1;
  assign w_block   = 1'b0;
`endif

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      r_tx <= c_idle_word;
      r_oe <= '1;
    end else if (cmd_valid && cmd_ready) begin
      r_tx <= cmd_data;
      r_oe <= cmd_oe;
    end else begin
      r_tx <= c_idle_word;
      r_oe <= '1;
    end
  end

  assign TX_DATA = w_block ? c_idle_word : r_tx;
  assign OE_DATA = w_block ? '1 : r_oe;

endmodule

`default_nettype wire

// File: tb/tb_ddr4_ca_lane_ctrl.sv
// ============================================================================
// Module : tb_ddr4_ca_lane_ctrl
// Desc   : Self-checking bench for ddr4_ca_lane_ctrl (schedule-level model).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ddr4_ca_lane_ctrl;

  localparam int          G        = 4;
  localparam int          NL       = 8;
  localparam logic [31:0] IDLE_W   = 32'hFFFF_FFFF;

  logic        FAB_CLK = 1'b0;
  logic        ARST_N;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_data, cmd_oe;
  logic [31:0] TX_DATA, OE_DATA;
  logic        adj_req;
  logic [2:0]  adj_lane;
  logic        adj_load;
  logic [7:0]  adj_target;
  logic        adj_busy, adj_done, adj_err;
  logic [2:0]  tap_rd_lane;
  logic [7:0]  tap_rd_data;
  logic [7:0]  DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD;
  logic [7:0]  DELAY_LINE_OUT_OF_RANGE;

  ddr4_ca_lane_ctrl #(
    .NUM_LANES(NL), .TAP_W(8), .LOAD_TAP(1), .MOVE_GAP(G), .IDLE_PATTERN(8'hFF)
  ) dut (
    .FAB_CLK(FAB_CLK), .ARST_N(ARST_N),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data), .cmd_oe(cmd_oe),
    .TX_DATA(TX_DATA), .OE_DATA(OE_DATA),
    .adj_req(adj_req), .adj_lane(adj_lane), .adj_load(adj_load), .adj_target(adj_target),
    .adj_busy(adj_busy), .adj_done(adj_done), .adj_err(adj_err),
    .tap_rd_lane(tap_rd_lane), .tap_rd_data(tap_rd_data),
    .DELAY_LINE_MOVE(DELAY_LINE_MOVE), .DELAY_LINE_DIRECTION(DELAY_LINE_DIRECTION),
    .DELAY_LINE_LOAD(DELAY_LINE_LOAD), .DELAY_LINE_OUT_OF_RANGE(DELAY_LINE_OUT_OF_RANGE)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge FAB_CLK);
    #1;
  endtask

  // Model state: per-interval expectations for the sequencer, tap table, command word.
  logic        m_valid = 1'b0;
  logic        m_busy  = 1'b0;
  logic        m_done  = 1'b0;
  logic        m_err   = 1'b0;
  logic [7:0]  m_move  = '0;
  logic [7:0]  m_dir   = '0;
  logic [7:0]  m_load  = '0;
  int          m_tap [NL];
  logic [31:0] m_tx_q, m_oe_q;
  logic        exp_ready;

`ifdef CA_ADJ_CMD_BLOCK_EN
  assign exp_ready = ~m_busy;
`else
  assign exp_ready = 1'b1;
`endif

  always @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      m_tx_q <= IDLE_W;
      m_oe_q <= 32'hFFFF_FFFF;
    end else if (cmd_valid && exp_ready) begin
      m_tx_q <= cmd_data;
      m_oe_q <= cmd_oe;
    end else begin
      m_tx_q <= IDLE_W;
      m_oe_q <= 32'hFFFF_FFFF;
    end
  end

  always @(negedge FAB_CLK) begin
    if (m_valid) begin
      logic [31:0] etx, eoe;
`ifdef CA_ADJ_CMD_BLOCK_EN
      etx = m_busy ? IDLE_W : m_tx_q;
      eoe = m_busy ? 32'hFFFF_FFFF : m_oe_q;
`else
      etx = m_tx_q;
      eoe = m_oe_q;
`endif
      chk("tx_data", TX_DATA, etx);
      chk("oe_data", OE_DATA, eoe);
      chk("cmd_ready", cmd_ready, exp_ready);
      chk("adj_busy", adj_busy, m_busy);
      chk("adj_done", adj_done, m_done);
      chk("adj_err", adj_err, m_err);
      chk("dl_move", DELAY_LINE_MOVE, m_move);
      chk("dl_load", DELAY_LINE_LOAD, m_load);
      chk("dl_dir", DELAY_LINE_DIRECTION & m_move, m_dir);
      if (!m_busy) chk("tap_rd", tap_rd_data, 8'(m_tap[tap_rd_lane]));
    end
  end

  // One adjust request; expectations come from the step schedule (pulse every 1+G cycles).
  task automatic adj_op(input int lane, input bit load, input int target,
                        input bit oor, input bit poke, output int done_j);
    int start, k, last_j;
    bit up, err;
    start  = m_tap[lane];
    up     = (target > start);
    k      = up ? target - start : start - target;
    err    = oor && !load && (k > 0);
    if (load)        last_j = 2;
    else if (k == 0) last_j = 1;
    else if (err)    last_j = 1 + (1 + G);
    else             last_j = 1 + k * (1 + G);
    adj_req    = 1'b1;
    adj_lane   = 3'(lane);
    adj_load   = load;
    adj_target = 8'(target);
    DELAY_LINE_OUT_OF_RANGE = oor ? (8'b1 << lane) : 8'h00;
    done_j = -1;
    step();
    adj_req = 1'b0;
    for (int j = 1; j <= last_j + 3; j++) begin
      m_busy = (j <= last_j);
      m_done = (j == last_j) && !err;
      m_err  = (j == last_j) && err;
      m_move = '0;
      m_dir  = '0;
      m_load = '0;
      if (!load && j < last_j && ((j - 1) % (1 + G)) == 0) begin
        m_move[lane] = 1'b1;
        m_dir[lane]  = up;
      end
      if (load && j == 1) m_load[lane] = 1'b1;
      if (j == last_j) m_tap[lane] = load ? 1 : (err ? start : target);
      if (poke && j == 3) begin
        adj_req  = 1'b1;
        adj_lane = 3'((lane + 1) % NL);
        adj_load = 1'b1;
      end else begin
        adj_req = 1'b0;
      end
      @(negedge FAB_CLK);
      if (adj_done && done_j < 0) done_j = j;
      step();
    end
    adj_req = 1'b0;
    DELAY_LINE_OUT_OF_RANGE = 8'h00;
  endtask

  // After reset release: broadcast load for exactly one cycle, then idle.
  task automatic init_check();
    int ones, stray;
    ones  = 0;
    stray = 0;
    for (int j = 1; j <= 4; j++) begin
      @(posedge FAB_CLK);
      @(negedge FAB_CLK);
      if (DELAY_LINE_LOAD == 8'hFF) ones++;
      else if (DELAY_LINE_LOAD != 8'h00) stray++;
      if (DELAY_LINE_MOVE != 8'h00) stray++;
    end
    chk("init_load_cycles", ones, 1);
    chk("init_stray_pulse", stray, 0);
    chk("init_busy_end", adj_busy, 1'b0);
    for (int i = 0; i < NL; i++) m_tap[i] = 1;
    step();
  endtask

  task automatic cmd_burst();
    logic [31:0] vd [4];
    logic [31:0] vo [4];
    bit          vv [4];
    vd = '{32'hA5A5_0F0F, 32'h0000_0000, 32'hDEAD_BEEF, 32'h8421_7BDE};
    vo = '{32'hFFFF_0000, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 32'h0000_0000};
    vv = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      cmd_valid = vv[i];
      cmd_data  = vd[i];
      cmd_oe    = vo[i];
      step();
    end
    cmd_valid = 1'b0;
    cmd_data  = '0;
    cmd_oe    = '0;
  endtask

  int dj;

  initial begin
    ARST_N = 1'b0;
    cmd_valid = 1'b0; cmd_data = '0; cmd_oe = '0;
    adj_req = 1'b0; adj_lane = '0; adj_load = 1'b0; adj_target = '0;
    tap_rd_lane = '0; DELAY_LINE_OUT_OF_RANGE = '0;
    for (int i = 0; i < NL; i++) m_tap[i] = 1;

    #12;
    chk("rst_tx", TX_DATA, 32'hFFFF_FFFF);
    chk("rst_oe", OE_DATA, 32'hFFFF_FFFF);
    chk("rst_move", DELAY_LINE_MOVE, 8'h00);
    chk("rst_load", DELAY_LINE_LOAD, 8'h00);
    chk("rst_dir", DELAY_LINE_DIRECTION, 8'h00);
    chk("rst_busy", adj_busy, 1'b1);
    chk("rst_done_err", {adj_done, adj_err}, 2'b00);
    chk("rst_tap", tap_rd_data, 8'd1);
`ifndef CA_ADJ_CMD_BLOCK_EN
    chk("rst_ready", cmd_ready, 1'b1);
`endif
    #10 ARST_N = 1'b1;
    init_check();
    m_valid = 1'b1;

    cmd_valid = 1'b1; cmd_data = 32'h1234_5678; cmd_oe = 32'hFFFF_FFFF;
    step();
    cmd_valid = 1'b0; cmd_data = '0; cmd_oe = '0;
    @(negedge FAB_CLK);
    chk("cmd_lit", TX_DATA, 32'h1234_5678);
    step();
    @(negedge FAB_CLK);
    chk("idle_lit", TX_DATA, 32'hFFFF_FFFF);
    step();
    cmd_burst();
    repeat (2) step();

    tap_rd_lane = 3'd3;
    adj_op(3, 1'b0, 5, 1'b0, 1'b1, dj);
    chk("up_done_cycle", dj, 21);
    chk("up_tap_lit", tap_rd_data, 8'd5);
    adj_op(3, 1'b0, 2, 1'b0, 1'b0, dj);
    chk("down_done_cycle", dj, 16);
    chk("down_tap_lit", tap_rd_data, 8'd2);
    adj_op(3, 1'b0, 2, 1'b0, 1'b0, dj);
    chk("equal_done_cycle", dj, 1);

    tap_rd_lane = 3'd5;
    adj_op(5, 1'b0, 3, 1'b0, 1'b0, dj);
    chk("l5_done_cycle", dj, 11);
    adj_op(5, 1'b1, 0, 1'b0, 1'b0, dj);
    chk("load_done_cycle", dj, 2);
    chk("load_tap_lit", tap_rd_data, 8'd1);

    tap_rd_lane = 3'd0;
    adj_op(0, 1'b0, 9, 1'b1, 1'b0, dj);
    chk("err_no_done", dj, -1);
    chk("err_tap_lit", tap_rd_data, 8'd1);

    tap_rd_lane = 3'd6;
    fork
      adj_op(6, 1'b0, 3, 1'b0, 1'b0, dj);
      begin
        repeat (2) step();
        cmd_burst();
      end
    join
    chk("conc_done_cycle", dj, 11);

    // Reset in the middle of a GAP, with a stray request while busy.
    m_valid = 1'b0;
    tap_rd_lane = 3'd3;
    adj_req = 1'b1; adj_lane = 3'd3; adj_load = 1'b0; adj_target = 8'd9;
    step();
    adj_req = 1'b0;
    @(negedge FAB_CLK);
    chk("rst_mid_pre_move", DELAY_LINE_MOVE, 8'h08);
    step();
    adj_req = 1'b1; adj_lane = 3'd1; adj_load = 1'b1;
    step();
    adj_req = 1'b0;
    #2 ARST_N = 1'b0;
    #1;
    chk("rst_mid_move", DELAY_LINE_MOVE, 8'h00);
    chk("rst_mid_load", DELAY_LINE_LOAD, 8'h00);
    chk("rst_mid_busy", adj_busy, 1'b1);
    chk("rst_mid_tap", tap_rd_data, 8'd1);
    @(posedge FAB_CLK);
    @(negedge FAB_CLK);
    #2 ARST_N = 1'b1;
    init_check();
    m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
    m_move = '0; m_load = '0; m_dir = '0;
    m_valid = 1'b1;
    repeat (4) step();
    chk("post_rst_tap_lit", tap_rd_data, 8'd1);
    m_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
